branch_predict_ctrl: RTL

BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

---
 rtl/branch_predict_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped branch predictor with 2-bit saturating counters and a target per entry.
// Optional macro BP_STATS_EN adds saturating BranchCount / MispredCount statistics outputs.
module branch_predict_ctrl #(
    parameter int          ENTRIES  = 16,
    parameter logic [2:0]  NOBRANCH = 3'd0
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        ValidE,
    input  logic [2:0]  BranchTypeE,
    input  logic        BranchE,
    input  logic [31:0] PCE,
    input  logic [31:0] BranchTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] RedirectPCE
`ifdef BP_STATS_EN
    ,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredCount
`endif
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = 32 - IDXW - 2;

    logic            tbl_valid  [ENTRIES];
    logic [TAGW-1:0] tbl_tag    [ENTRIES];
    logic [1:0]      tbl_ctr    [ENTRIES];
    logic [31:0]     tbl_target [ENTRIES];

    logic [IDXW-1:0] idx_f;
    logic [IDXW-1:0] idx_e;
    logic [TAGW-1:0] tag_f;
    logic [TAGW-1:0] tag_e;
    logic            hit_f;
    logic            hit_e;
    logic            resolve;
    logic            target_wrong;
    logic            unused_pcf_low;

    assign idx_f = PCF[IDXW+1:2];
    assign tag_f = PCF[31:IDXW+2];
    assign idx_e = PCE[IDXW+1:2];
    assign tag_e = PCE[31:IDXW+2];

    assign unused_pcf_low = &{1'b0, PCF[1:0]};

    // Fetch-side lookup reads the table as it stood before this edge; no bypass from EX.
    assign hit_f       = tbl_valid[idx_f] && (tbl_tag[idx_f] == tag_f);
    assign PredTakenF  = hit_f && tbl_ctr[idx_f][1];
    assign PredTargetF = PredTakenF ? tbl_target[idx_f] : 32'd0;

    assign hit_e        = tbl_valid[idx_e] && (tbl_tag[idx_e] == tag_e);
    assign resolve      = ValidE && (BranchTypeE != NOBRANCH);
    assign target_wrong = (PredTargetE != BranchTargetE);
    assign MispredictE  = resolve &&
                          ((BranchE != PredTakenE) || (BranchE && PredTakenE && target_wrong));
    assign RedirectPCE  = BranchE ? BranchTargetE : (PCE + 32'd4);

    // Reset wins over any coincident update; misses only allocate on a taken outcome.
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_ctr[i]    <= 2'd1;
                tbl_target[i] <= 32'd0;
            end
        end else if (resolve) begin
            if (hit_e) begin
                if (BranchE) begin
                    if (tbl_ctr[idx_e] != 2'd3)
                        tbl_ctr[idx_e] <= tbl_ctr[idx_e] + 2'd1;
                    tbl_target[idx_e] <= BranchTargetE;
                end else if (tbl_ctr[idx_e] != 2'd0) begin
                    tbl_ctr[idx_e] <= tbl_ctr[idx_e] - 2'd1;
                end
            end else if (BranchE) begin
                tbl_valid[idx_e]  <= 1'b1;
                tbl_tag[idx_e]    <= tag_e;
                tbl_ctr[idx_e]    <= 2'd2;
                tbl_target[idx_e] <= BranchTargetE;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            BranchCount  <= 32'd0;
            MispredCount <= 32'd0;
        end else begin
            if (resolve && (BranchCount != 32'hFFFF_FFFF))
                BranchCount <= BranchCount + 32'd1;
            if (MispredictE && (MispredCount != 32'hFFFF_FFFF))
                MispredCount <= MispredCount + 32'd1;
        end
    end
`endif

endmodule
